// File: rtl/conv_row_ctrl_if.sv
// Weight-in, pixel-in and result-out streams of one convolution row sequencer.
// master = upstream buffers / result sink, slave = the sequencer.
interface conv_row_ctrl_if #(
  parameter int WEIGHT_BW = 8,
  parameter int DATA_BW   = 8,
  parameter int SUM_BW    = 16
);
  logic                        w_valid;
  logic                        w_ready;
  logic signed [WEIGHT_BW-1:0] w_data;
  logic                        x_valid;
  logic                        x_ready;
  logic signed [DATA_BW-1:0]   x_data;
  logic                        y_valid;
  logic signed [SUM_BW-1:0]    y_data;

  modport master (
    output w_valid, w_data, x_valid, x_data,
    input  w_ready, x_ready, y_valid, y_data
  );

  modport slave (
    input  w_valid, w_data, x_valid, x_data,
    output w_ready, x_ready, y_valid, y_data
  );
endinterface

// File: rtl/conv_row_ctrl.sv
// Row sequencer: loads KERNEL_SIZE weights, streams ROW_LEN pixels into the PE chain, tags full windows.
// Result for slot j appears 2+PIPE_LAT cycles after its accept; weight load may stall, pixel stream and results never do.
module conv_row_ctrl #(
  parameter int KERNEL_SIZE = 5,
  parameter int WEIGHT_BW   = 8,
  parameter int DATA_BW     = 8,
  parameter int SUM_BW      = 16,
  parameter int ADDR_BW     = 5,
  parameter int CONV_ADDR   = 0,
  parameter int ROW_LEN     = 32,
  parameter int PIPE_LAT    = 5,
  parameter int CNT_BW      = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic                        i_reuse_w,
  input  logic signed [SUM_BW-1:0]    i_bias,
  conv_row_ctrl_if.slave              bus,
  output logic                        o_pe_w_en,
  output logic [ADDR_BW-1:0]          o_pe_addr,
  output logic signed [WEIGHT_BW-1:0] o_pe_w,
  output logic signed [DATA_BW-1:0]   o_pe_x,
  output logic signed [SUM_BW-1:0]    o_pe_psum,
  input  logic signed [SUM_BW-1:0]    i_pe_psum,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err
);

  localparam int              W_BASE    = CONV_ADDR * KERNEL_SIZE;
  localparam logic [CNT_BW-1:0] W_LAST    = CNT_BW'(KERNEL_SIZE - 1);
  localparam logic [CNT_BW-1:0] X_LAST    = CNT_BW'(ROW_LEN - 1);
  localparam logic [CNT_BW-1:0] D_LAST    = CNT_BW'(PIPE_LAT);
  localparam logic [CNT_BW-1:0] TAG_FIRST = CNT_BW'(KERNEL_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_BW-1:0]           cnt_q, cnt_d;
  logic [PIPE_LAT:0]           tag_q;
  logic                        pe_w_en_q;
  logic [ADDR_BW-1:0]          pe_addr_q;
  logic signed [WEIGHT_BW-1:0] pe_w_q;
  logic signed [DATA_BW-1:0]   pe_x_q;
  logic signed [SUM_BW-1:0]    psum_q;
  logic                        y_valid_q;
  logic signed [SUM_BW-1:0]    y_data_q;
  logic                        done_q;
  logic                        err_q;

  logic loading, streaming, w_hs, tag_push, start_ok;

  assign loading   = (state_q == S_LOAD_W);
  assign streaming = (state_q == S_STREAM);
  assign w_hs      = loading & bus.w_valid;
  assign start_ok  = (state_q == S_IDLE) & i_start;
  // Only slots that complete a full KERNEL_SIZE window produce a result.
  assign tag_push  = streaming & (cnt_q >= TAG_FIRST);

  assign bus.w_ready = loading;
  assign bus.x_ready = streaming;
  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_data_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_pe_w_en   = pe_w_en_q;
  assign o_pe_addr   = pe_addr_q;
  assign o_pe_w      = pe_w_q;
  assign o_pe_x      = pe_x_q;
  assign o_pe_psum   = psum_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

  // cnt_q is the weight index in LOAD_W, the slot index in STREAM and the drain timer in DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = i_reuse_w ? S_STREAM : S_LOAD_W;
          cnt_d   = '0;
        end
      end
      S_LOAD_W: begin
        if (w_hs) begin
          if (cnt_q == W_LAST) begin
            state_d = S_STREAM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_BW'(1);
          end
        end
      end
      S_STREAM: begin
        if (cnt_q == X_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == D_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q     <= '0;
      pe_w_en_q <= 1'b0;
      pe_addr_q <= '0;
      pe_w_q    <= '0;
      pe_x_q    <= '0;
      psum_q    <= '0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pe_w_en_q <= w_hs;
      if (w_hs) begin
        pe_addr_q <= ADDR_BW'(W_BASE + int'(cnt_q));
        pe_w_q    <= bus.w_data;
      end
      // The PE chain is free-running: a missing pixel still consumes its slot as a zero.
      pe_x_q <= (streaming && bus.x_valid) ? bus.x_data : '0;
      if (start_ok) begin
        psum_q <= i_bias;
        err_q  <= 1'b0;
      end else if (streaming && !bus.x_valid) begin
        err_q <= 1'b1;
      end
      tag_q     <= {tag_q[PIPE_LAT-1:0], tag_push};
      y_valid_q <= tag_q[PIPE_LAT];
      if (tag_q[PIPE_LAT]) begin
        y_data_q <= i_pe_psum;
      end
      done_q <= (state_q == S_DONE);
    end
  end

endmodule
